// File: rtl/dac_adv_pkg.sv
// dac_advance_seq shared types: FSM encoding, default widths, bus slicing.
package dac_adv_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    FIRE    = 2'd2,
    HOLDOFF = 2'd3
  } seq_state_e;

  localparam int N_CH_DEF   = 8;
  localparam int DATA_W_DEF = 16;
  localparam int CNT_W_DEF  = 32;
  localparam int DEB_W_DEF  = 4;

  function automatic int lo_idx(input int k, input int w);
    return k * w;
  endfunction

endpackage

// File: rtl/dac_chan_cond.sv
// One DAC channel: window, threshold and pass status.
// Macro DAC_SIGNED_CMP_EN selects signed data/threshold compares.
module dac_chan_cond
  import dac_adv_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic [CNT_W-1:0]  i_cnt,
  input  logic [CNT_W-1:0]  i_start,
  input  logic [CNT_W-1:0]  i_stop,
  input  logic [DATA_W-1:0] i_data,
  input  logic [DATA_W-1:0] i_thrsh,
  input  logic              i_en,
  input  logic              i_pol,
  input  logic              i_edge,
  output logic              o_in_win,
  output logic              o_thr,
  output logic              o_status
);

  logic w_ge;
  logic w_le;

`ifdef DAC_SIGNED_CMP_EN
  assign w_ge = $signed(i_data) >= $signed(i_thrsh);
  assign w_le = $signed(i_data) <= $signed(i_thrsh);
`else
  assign w_ge = i_data >= i_thrsh;
  assign w_le = i_data <= i_thrsh;
`endif

  // window is always unsigned: start inclusive, stop exclusive
  assign o_in_win = (i_cnt >= i_start) && (i_stop > i_cnt);
  assign o_thr    = i_en & (i_pol ? w_ge : w_le);
  assign o_status = (o_thr ^ i_edge) | ~o_in_win | ~i_en;

endmodule

// File: rtl/dac_advance_seq.sv
// N-channel DAC advance sequencer: debounce, one-cycle pulse, hold-off.
// Build option DAC_SIGNED_CMP_EN (see dac_chan_cond).
module dac_advance_seq
  import dac_adv_pkg::*;
#(
  parameter int N_CH   = N_CH_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = CNT_W_DEF,
  parameter int DEB_W  = DEB_W_DEF
) (
  input  logic                     dataclk,
  input  logic                     reset,
  input  logic                     sample_strobe,
  input  logic                     arm,
  input  logic [N_CH-1:0]          DAC_en,
  input  logic [N_CH-1:0]          DAC_edge_type,
  input  logic [N_CH-1:0]          DAC_thrsh_pol,
  input  logic [N_CH*DATA_W-1:0]   DAC_data,
  input  logic [N_CH*DATA_W-1:0]   DAC_thrsh,
  input  logic [N_CH*CNT_W-1:0]    DAC_start_win,
  input  logic [N_CH*CNT_W-1:0]    DAC_stop_win,
  input  logic [DEB_W-1:0]         debounce_len,
  input  logic [CNT_W-1:0]         holdoff_len,
  output logic [CNT_W-1:0]         state_counter,
  output logic [N_CH-1:0]          DAC_in_window,
  output logic [N_CH-1:0]          DAC_thresh_out,
  output logic                     DAC_advance,
  output logic [1:0]               seq_state
);

  localparam logic [CNT_W-1:0] C_ONE = CNT_W'(1);
  localparam logic [DEB_W:0]   D_ONE = (DEB_W + 1)'(1);

  seq_state_e       r_state;
  seq_state_e       w_state_nx;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nx;
  logic [CNT_W-1:0] w_cnt_inc;
  logic [DEB_W-1:0] r_deb;
  logic [DEB_W-1:0] w_deb_nx;
  logic [DEB_W-1:0] w_deb_sat;
  logic [DEB_W:0]   w_deb_inc;
  logic [DEB_W:0]   w_deb_tgt;
  logic [CNT_W-1:0] r_ho;
  logic [CNT_W-1:0] w_ho_nx;
  logic [N_CH-1:0]  r_in_win;
  logic [N_CH-1:0]  r_thr;
  logic [N_CH-1:0]  w_in_win;
  logic [N_CH-1:0]  w_thr;
  logic [N_CH-1:0]  w_status;
  logic             w_check;

  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    localparam int LD = lo_idx(k, DATA_W);
    localparam int LC = lo_idx(k, CNT_W);
    dac_chan_cond #(
      .DATA_W (DATA_W),
      .CNT_W  (CNT_W)
    ) u_cond (
      .i_cnt    (r_cnt),
      .i_start  (DAC_start_win[LC +: CNT_W]),
      .i_stop   (DAC_stop_win[LC +: CNT_W]),
      .i_data   (DAC_data[LD +: DATA_W]),
      .i_thrsh  (DAC_thrsh[LD +: DATA_W]),
      .i_en     (DAC_en[k]),
      .i_pol    (DAC_thrsh_pol[k]),
      .i_edge   (DAC_edge_type[k]),
      .o_in_win (w_in_win[k]),
      .o_thr    (w_thr[k]),
      .o_status (w_status[k])
    );
  end

  // an all-disabled bank must never qualify
  assign w_check   = (&w_status) && (|DAC_en);
  assign w_cnt_inc = (&r_cnt) ? r_cnt : r_cnt + C_ONE;
  assign w_deb_inc = {1'b0, r_deb} + D_ONE;
  assign w_deb_sat = (&r_deb) ? r_deb : w_deb_inc[DEB_W-1:0];
  assign w_deb_tgt = (debounce_len == '0) ? D_ONE
                   : {1'b0, debounce_len};

  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_deb_nx   = r_deb;
    w_ho_nx    = r_ho;
    case (r_state)
      IDLE: begin
        w_cnt_nx = '0;
        w_deb_nx = '0;
        w_ho_nx  = '0;
        if (arm) w_state_nx = ARMED;
      end
      ARMED: begin
        if (sample_strobe) begin
          w_cnt_nx = w_cnt_inc;
          if (w_check && (w_deb_inc >= w_deb_tgt))
            w_state_nx = FIRE;
          else if (w_check)
            w_deb_nx = w_deb_sat;
          else
            w_deb_nx = '0;
        end
      end
      FIRE: begin
        w_cnt_nx   = '0;
        w_deb_nx   = '0;
        w_ho_nx    = holdoff_len;
        w_state_nx = (holdoff_len != '0) ? HOLDOFF : ARMED;
      end
      HOLDOFF: begin
        if (sample_strobe) begin
          w_ho_nx  = r_ho - C_ONE;
          w_cnt_nx = w_cnt_inc;
          if (r_ho <= C_ONE) w_state_nx = ARMED;
        end
      end
      default: w_state_nx = IDLE;
    endcase
    if (!arm) begin
      w_state_nx = IDLE;
      w_cnt_nx   = '0;
      w_deb_nx   = '0;
      w_ho_nx    = '0;
    end
  end

  always_ff @(posedge dataclk or negedge reset) begin
    if (!reset) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_deb    <= '0;
      r_ho     <= '0;
      r_in_win <= '0;
      r_thr    <= '0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
      r_deb   <= w_deb_nx;
      r_ho    <= w_ho_nx;
      if (sample_strobe) begin
        r_in_win <= w_in_win;
        r_thr    <= w_thr;
      end
    end
  end

  assign state_counter  = r_cnt;
  assign DAC_in_window  = r_in_win;
  assign DAC_thresh_out = r_thr;
  assign DAC_advance    = (r_state == FIRE);
  assign seq_state      = r_state;

endmodule

// File: doc/dac_advance_seq.md
Name: dac_advance_seq

Overview:
- Parametrised, sequential successor of the two-channel DAC advance logic.
- Evaluates N_CH DAC channels per sample strobe. Each channel has a window, threshold, polarity, edge type and enable.
- Owns the state-window counter. Requires the advance condition to hold for a programmable number of consecutive samples. Then emits a one-cycle advance pulse and enters a programmable hold-off.
- Sits between the per-sample DAC datapath (HPF output) and the stim/trigger state machine.

Parameters:
- N_CH, 8, number of DAC channels evaluated.
- DATA_W, 16, width of DAC sample and threshold.
- CNT_W, 32, width of the state counter, window bounds and hold-off length.
- DEB_W, 4, width of the debounce length and debounce counter.

Ports:
- dataclk  in  1  system clock; all logic is on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- sample_strobe  in  1  one-cycle pulse; one new DAC sample set is valid this cycle.
- arm  in  1  level; high enables the sequencer, low returns it to IDLE.
- DAC_en  in  N_CH  per-channel enable.
- DAC_edge_type  in  N_CH  per-channel edge type. 1 = the threshold result must be low to pass.
- DAC_thrsh_pol  in  N_CH  1 = pass when data >= threshold; 0 = pass when data <= threshold.
- DAC_data  in  N_CH*DATA_W  per-channel offset-corrected samples; channel k is at [k*DATA_W +: DATA_W].
- DAC_thrsh  in  N_CH*DATA_W  per-channel thresholds, same packing as DAC_data.
- DAC_start_win  in  N_CH*CNT_W  window start (inclusive).
- DAC_stop_win  in  N_CH*CNT_W  window stop (exclusive).
- debounce_len  in  DEB_W  consecutive passing samples required; 0 is treated as 1.
- holdoff_len  in  CNT_W  strobes to ignore after an advance.
- state_counter  out  CNT_W  samples elapsed since the last advance or arm.
- DAC_in_window  out  N_CH  registered per-channel window flags.
- DAC_thresh_out  out  N_CH  registered per-channel threshold flags, gated by enable.
- DAC_advance  out  1  one-cycle advance pulse.
- seq_state  out  2  current FSM state.

Behaviour:
- Reset (reset low, asynchronous): every output is 0, seq_state = IDLE, and the debounce and hold-off counters are 0.
- Per-channel condition, combinational from current inputs and state_counter:
  - in_win = (state_counter >= start) && (stop > state_counter).
  - thr = en ? (pol ? data >= thrsh : data <= thrsh) : 0.
  - status = (thr ^ edge) | ~in_win | ~en.
  - Comparisons are unsigned by default.
- check = (&status) && (|DAC_en). With all channels disabled, check is never true.
- DAC_in_window and DAC_thresh_out register on each sample_strobe only; they hold between strobes.
- FSM states are IDLE=0, ARMED=1, FIRE=2, HOLDOFF=3.
  - IDLE: state_counter = 0 and deb_cnt = 0. Goes to ARMED when arm = 1.
  - ARMED, on each strobe:
    - If check and deb_cnt+1 >= max(debounce_len,1), go to FIRE.
    - Else if check, deb_cnt increments and saturates at the all-ones value.
    - Else deb_cnt clears.
    - state_counter increments on every ARMED strobe and saturates at all-ones (no wrap).
    - Evaluation uses the pre-increment counter value.
  - FIRE, exactly one cycle:
    - DAC_advance = 1.
    - state_counter and deb_cnt clear; ho_cnt loads holdoff_len.
    - Next state is HOLDOFF if holdoff_len != 0, else ARMED.
  - HOLDOFF:
    - Each strobe decrements ho_cnt and increments state_counter.
    - Goes to ARMED after the strobe that brings ho_cnt to 0.
    - The condition is not evaluated.
- Latency: the advance pulse is registered and appears the cycle after the qualifying strobe.
- DAC_advance is never high on two consecutive cycles.
- arm low in any state: next cycle is IDLE and counters clear. If FIRE is in progress, its pulse still completes.
- arm rising on the same cycle as a strobe: the strobe is ignored; the counter starts at 0.
- A strobe on the FIRE cycle is ignored.
- Inputs are sampled only at strobes. Changes between strobes have no effect except on the combinational check.

Optional Feature:
- Macro DAC_SIGNED_CMP_EN.
- Defined: data-versus-threshold comparisons are two's-complement signed, for bipolar HPF output.
- Undefined: unsigned, matching the legacy offset-binary DAC data.
- Window comparisons are always unsigned.

Decomposition:
- Package dac_adv_pkg holds:
  - seq_state encoding constants IDLE/ARMED/FIRE/HOLDOFF.
  - Default widths.
  - A helper function for the packed-bus slice index.
- Sub-module dac_chan_cond, generated N_CH times: computes in_win, thr and status for one channel. It holds the DAC_SIGNED_CMP_EN compare switch.
- Top level holds the FSM, counters and output registers.

Test Plan:
- Reset mid-HOLDOFF: with arm=1 and holdoff_len=5, drive reset low for 1 cycle after 2 hold-off strobes -> all outputs 0, seq_state=IDLE, DAC_advance never asserts.
- Basic advance: N_CH=8, ch0 only enabled, pol=1, edge=0, thrsh=0x8000, window 10..20, debounce_len=1. Data 0x9000 from strobe 12 -> DAC_advance pulses one cycle after strobe 12, then state_counter=0.
- Debounce: debounce_len=3, data passes at strobes 5, 6, fails at 7, passes 8, 9, 10 -> single pulse after strobe 10.
- Hold-off: holdoff_len=4 with a continuously passing condition -> pulses separated by exactly 5 strobes.
- All disabled: DAC_en=0 with any data -> no pulse over 100 strobes; state_counter reaches 100.
- Saturation and signed: CNT_W=8, no pass -> state_counter holds at 255. With DAC_SIGNED_CMP_EN, data 0xFFFF vs thrsh 0x0001, pol=0 -> DAC_thresh_out[0]=1; without the macro -> 0.
